// File: rtl/dm_ext.sv
// dm_ext: MEM-stage data memory with word/half/byte access, load extension
// and a post-reset clear sweep. Optional write log: DM_WRITE_LOG_EN.
//
// Ports:
//   clk, reset (sync, active-low)
//   MemWrite, MemOp[2:0], PC[31:0], addr[31:0], writeData[31:0]
//   readData[31:0] (extended load), busy (sweep), addrExc (bad access)
module dm_ext #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [2:0]  MemOp,
  input  logic [31:0] PC,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        busy,
  output logic        addrExc
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t state, state_n;

  logic [AW-1:0] cnt;
  logic          last;
  logic [31:0]   mem [DEPTH];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          oor;
  logic          is_h, is_b, sx;
  logic          mis, exc_raw;
  logic          st_we, clr_we;

  logic [31:0]   rword;
  logic [15:0]   hsel;
  logic [7:0]    bsel;
  logic [31:0]   rd_ext;

  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   merged;

  // Address decode
  assign off = addr - BASE;
  assign idx = off[AW+1:2];
  assign oor = (addr < BASE)
            || ({2'b00, off[31:2]} >= 32'(DEPTH));

  always_comb begin
    is_h = 1'b0;
    is_b = 1'b0;
    sx   = 1'b0;
    unique case (1'b1)
      (MemOp == 3'b001): is_h = 1'b1;
      (MemOp == 3'b010): begin
        is_h = 1'b1;
        sx   = 1'b1;
      end
      (MemOp == 3'b011): is_b = 1'b1;
      (MemOp == 3'b100): begin
        is_b = 1'b1;
        sx   = 1'b1;
      end
      default: ;
    endcase
  end

  assign mis = (is_h & addr[0])
             | (~is_h & ~is_b & (addr[1:0] != 2'b00));
  assign exc_raw = mis | oor;

  // Reset itself counts as busy so outputs are quiet before the
  // state register has seen its first edge.
  assign busy    = ~reset | (state == CLEAR);
  assign addrExc = exc_raw & ~busy;

  // Load path
  assign rword = mem[idx];
  assign hsel  = addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    bsel = rword[7:0];
    unique case (addr[1:0])
      2'd0: bsel = rword[7:0];
      2'd1: bsel = rword[15:8];
      2'd2: bsel = rword[23:16];
      2'd3: bsel = rword[31:24];
      default: ;
    endcase
  end

  always_comb begin
    rd_ext = rword;
    unique case (1'b1)
      is_h: rd_ext = {{16{sx & hsel[15]}}, hsel};
      is_b: rd_ext = {{24{sx & bsel[7]}}, bsel};
      default: ;
    endcase
  end

  assign readData = (busy | exc_raw) ? 32'h0 : rd_ext;

  // Store path: replicate data across lanes, then byte-enable merge
  always_comb begin
    be = 4'b1111;
    wd = writeData;
    unique case (1'b1)
      is_h: begin
        be = addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{writeData[15:0]}};
      end
      is_b: begin
        be = 4'b0001 << addr[1:0];
        wd = {4{writeData[7:0]}};
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_merge
    assign merged[8*i +: 8] = be[i] ? wd[8*i +: 8]
                                    : rword[8*i +: 8];
  end

  assign st_we  = MemWrite & ~busy & ~exc_raw;
  assign clr_we = reset & (state == CLEAR);

  // Sweep FSM
  assign last = (cnt == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) state <= CLEAR;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      CLEAR: if (last) state_n = IDLE;
      IDLE:  state_n = IDLE;
      default: state_n = CLEAR;
    endcase
  end

  // Counter parks at DEPTH-1 rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == CLEAR && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else if (st_we) begin
      mem[idx] <= merged;
    end
  end

`ifdef DM_WRITE_LOG_EN
  always_ff @(posedge clk) begin
    if (st_we) begin
      $display("@%h: *%h <= %h", PC,
               {addr[31:2], 2'b00}, merged);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

  logic unused_off;
  assign unused_off = ^off[1:0];

endmodule

// File: tb/tb_dm_ext.sv
// tb_dm_ext: directed bench for dm_ext (DEPTH=16) with a queued
// scoreboard checked by a negedge monitor.
module tb_dm_ext;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [2:0]  MemOp;
  logic [31:0] PC;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        busy;
  logic        addrExc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        exc;
    logic        bsy;
  } exp_t;

  exp_t q[$];

  localparam logic [2:0] LW  = 3'b000;
  localparam logic [2:0] LHU = 3'b001;
  localparam logic [2:0] LH  = 3'b010;
  localparam logic [2:0] LBU = 3'b011;
  localparam logic [2:0] LB  = 3'b100;
  localparam logic [2:0] RSV = 3'b111;

  dm_ext #(
    .DEPTH(16),
    .BASE (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .MemOp    (MemOp),
    .PC       (PC),
    .addr     (addr),
    .writeData(writeData),
    .readData (readData),
    .busy     (busy),
    .addrExc  (addrExc)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so every cycle's expectation
  // is checked at the negedge following the drive.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (readData !== e.rd || addrExc !== e.exc
          || busy !== e.bsy) begin
        errors++;
        $display("FAIL %s: got rd=%h exc=%b busy=%b want rd=%h exc=%b busy=%b",
                 e.nm, readData, addrExc, busy,
                 e.rd, e.exc, e.bsy);
      end
    end
  end

  task automatic drive(input logic we, input logic [2:0] mo,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit chk, input string nm,
                       input logic [31:0] erd, input logic eexc,
                       input logic ebsy);
    exp_t e;
    MemWrite  = we;
    MemOp     = mo;
    addr      = a;
    writeData = d;
    PC        = PC + 32'd4;
    if (chk) begin
      e.nm  = nm;
      e.rd  = erd;
      e.exc = eexc;
      e.bsy = ebsy;
      q.push_back(e);
    end
  endtask

  task automatic op(input logic we, input logic [2:0] mo,
                    input logic [31:0] a, input logic [31:0] d,
                    input string nm, input logic [31:0] erd,
                    input logic eexc, input logic ebsy);
    @(posedge clk);
    #1;
    drive(we, mo, a, d, 1'b1, nm, erd, eexc, ebsy);
  endtask

  task automatic sweep(input string nm, input int lim,
                       input int st_at);
    int n;
    n = 0;
    while (busy && n < lim) begin
      if (n == st_at)
        drive(1'b1, LW, 32'h8, 32'hFFFF_FFFF, 1'b1,
              "blk_st", 32'h0, 1'b0, 1'b1);
      else
        drive(1'b0, LW, 32'h0, 32'h0, 1'b0, "", 32'h0,
              1'b0, 1'b0);
      @(posedge clk);
      n++;
      #1;
    end
    MemWrite = 1'b0;
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL %s: got %0d edges want 16", nm, n);
    end
  endtask

  initial begin
    reset     = 1'b0;
    MemWrite  = 1'b0;
    MemOp     = LW;
    PC        = 32'h0000_0400;
    addr      = 32'h0;
    writeData = 32'h0;

    // Reset: busy high, outputs quiet even for a bad address
    op(1'b0, LW, 32'h5, 32'h0, "rst_a", 32'h0, 1'b0, 1'b1);
    op(1'b1, LW, 32'h0, 32'hAAAA_AAAA,
       "rst_b", 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    reset    = 1'b1;
    MemWrite = 1'b0;
    sweep("sweep1", 100, -1);

    for (int i = 0; i < 16; i++)
      op(1'b0, LW, 32'(i * 4), 32'h0, "clr_lw",
         32'h0, 1'b0, 1'b0);

    // Word store; same-cycle read shows pre-edge value
    op(1'b1, LW, 32'h4, 32'h1234_5678, "sw4", 32'h0, 1'b0, 1'b0);
    op(1'b0, LW, 32'h4, 32'h0, "lw4_a", 32'h1234_5678, 1'b0, 1'b0);

    op(1'b1, LBU, 32'h6, 32'h0000_0080, "sb6", 32'h34, 1'b0, 1'b0);
    op(1'b0, LB,  32'h6, 32'h0, "lb6",  32'hFFFF_FF80, 1'b0, 1'b0);
    op(1'b0, LBU, 32'h6, 32'h0, "lbu6", 32'h0000_0080, 1'b0, 1'b0);
    op(1'b0, LW,  32'h4, 32'h0, "lw4_b", 32'h1280_5678, 1'b0, 1'b0);

    op(1'b1, LHU, 32'h4, 32'h0000_BEEF, "sh4", 32'h5678, 1'b0, 1'b0);
    op(1'b0, LH,  32'h4, 32'h0, "lh4",  32'hFFFF_BEEF, 1'b0, 1'b0);
    op(1'b0, LHU, 32'h4, 32'h0, "lhu4", 32'h0000_BEEF, 1'b0, 1'b0);
    op(1'b0, LW,  32'h4, 32'h0, "lw4_c", 32'h1280_BEEF, 1'b0, 1'b0);
    op(1'b0, LH,  32'h6, 32'h0, "lh6",  32'h0000_1280, 1'b0, 1'b0);
    op(1'b0, LB,  32'h5, 32'h0, "lb5",  32'hFFFF_FFBE, 1'b0, 1'b0);
    op(1'b0, LBU, 32'h7, 32'h0, "lbu7", 32'h0000_0012, 1'b0, 1'b0);
    op(1'b0, RSV, 32'h4, 32'h0, "rsv4", 32'h1280_BEEF, 1'b0, 1'b0);

    // Misaligned / out of range
    op(1'b1, LW,  32'h5, 32'hDEAD_BEEF, "sw5", 32'h0, 1'b1, 1'b0);
    op(1'b0, LW,  32'h4, 32'h0, "lw4_d", 32'h1280_BEEF, 1'b0, 1'b0);
    op(1'b1, LHU, 32'h3, 32'h0000_1111, "sh3", 32'h0, 1'b1, 1'b0);
    op(1'b0, LW,  32'h0, 32'h0, "lw0", 32'h0, 1'b0, 1'b0);
    op(1'b0, LW,  32'h40, 32'h0, "lw40", 32'h0, 1'b1, 1'b0);
    op(1'b1, LB,  32'h41, 32'h55, "sb41", 32'h0, 1'b1, 1'b0);
    op(1'b0, LW,  32'h3C, 32'h0, "lw3c", 32'h0, 1'b0, 1'b0);

    // Restart sweep, abort it at cycle 7, blocked store mid-sweep
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, LW, 32'h0, 32'h0, 1'b0, "", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, LW, 32'h8, 32'hFFFF_FFFF, 1'b1,
          "rst_mid", 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, LW, 32'h4, 32'h0, 1'b1,
          "rel_busy", 32'h0, 1'b0, 1'b1);
    sweep("sweep2", 100, 5);

    op(1'b0, LW, 32'h8, 32'h0, "lw8", 32'h0, 1'b0, 1'b0);
    op(1'b0, LW, 32'h4, 32'h0, "lw4_e", 32'h0, 1'b0, 1'b0);
    op(1'b0, LW, 32'hC, 32'h0, "lwc", 32'h0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_ext.md
# dm_ext

Parametrised data memory for the MIPS datapath, successor to the single-width `dm`. It supports word, halfword and byte stores and loads, with sign or zero extension on loads. Misaligned and out-of-range accesses are flagged and suppressed. After reset, the array is cleared by a sequential sweep that holds `busy` high until every word is zero. It sits in the MEM stage between the ALU address output and the write-back mux.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words; power of two, ≥ 4.
- `BASE`, 32'h0000_0000: byte address of word 0; word-aligned.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low (reset asserted when `reset`=0).
- `MemWrite` in 1: store request this cycle.
- `MemOp` in 3: access size and extension.
  - 000 word.
  - 001 half, zero-extend.
  - 010 half, sign-extend.
  - 011 byte, zero-extend.
  - 100 byte, sign-extend.
  - 101–111 reserved, treated as word.
- `PC` in 32: instruction address; used only for the write log.
- `addr` in 32: byte address.
- `writeData` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `readData` out 32: extended load data.
- `busy` out 1: clear sweep in progress.
- `addrExc` out 1: misaligned or out-of-range access.

## Operation
- Word index: `idx = (addr - BASE) >> 2`. The access is out of range when `addr < BASE` or `idx ≥ DEPTH`.
- `addrExc` is combinational.
  - Set for word access with `addr[1:0] != 0`.
  - Set for half access with `addr[0] != 0`.
  - Set for any out-of-range access.
  - Driven regardless of `MemWrite`, but forced to 0 while `busy`.

Store (commits on rising edge when `MemWrite && !busy && !addrExc`):
- Word writes all four bytes.
- Half writes `writeData[15:0]`:
  - `addr[1]`=0 → bytes 1:0.
  - `addr[1]`=1 → bytes 3:2.
- Byte writes `writeData[7:0]` to byte lane `addr[1:0]`.
- Byte lane 0 is bits [7:0] (little-endian within the word).
- Untouched bytes are preserved.

Load (combinational from the array):
- Extract the lane matching `addr` and `MemOp`, then zero- or sign-extend to 32 bits.
- `readData` = 0 when `busy` or `addrExc`.

Clear-sweep FSM, two states:
- CLEAR:
  - While `reset`=0: state = CLEAR, counter = 0, `busy`=1, no array write.
  - After release: each cycle writes `mem[counter] = 0` and increments the counter.
  - On the edge that clears word `DEPTH-1`, go to IDLE.
- IDLE:
  - `busy`=0; normal access.
  - Returns to CLEAR only on `reset`=0.
- Counter width is `$clog2(DEPTH)`. It never wraps: the exit happens at `DEPTH-1`.

Stores requested while `busy` are dropped, not queued.

## Timing
- Reset values (while `reset`=0):
  - `busy`=1.
  - `readData`=0.
  - `addrExc`=0.
- Sweep latency:
  - `busy` falls exactly `DEPTH` rising edges after the first edge sampling `reset`=1.
  - Example: `DEPTH`=16 gives 16 cycles.
- Store latency: one edge. A load of the same address in the next cycle returns the new data.
- Same-cycle store and load to the same word: `readData` shows the pre-edge value until the edge.
- Reset asserted mid-sweep: the sweep restarts from word 0 after release.
- Reset asserted during a store: the store is not committed.
- No handshake beyond `busy`. The pipeline must stall on `busy`=1.

## Configuration
- `DM_WRITE_LOG_EN` defined:
  - Each committed store executes `$display("@%h: *%h <= %h", PC, {addr[31:2],2'b00}, merged_word)` on its commit edge.
  - `merged_word` is the full 32-bit word after the byte-lane merge.
  - Sweep writes are not logged.
- `DM_WRITE_LOG_EN` undefined: no display statements are compiled; functionality is identical.

## Test plan
- Use `DEPTH`=16 throughout.
- Reset sweep: hold `reset`=0 for 2 cycles, then release → `busy`=1 for exactly 16 edges, then 0. `lw` at every address 0x0..0x3C → `readData`=0.
- Word store/load: `sw` 0x12345678 to 0x4 → next-cycle `lw` 0x4 = 0x12345678. With the log enabled, it prints `@<PC>: *00000004 <= 12345678`.
- Byte/half stores with extension, after the word store above:
  - `sb` 0x80 to 0x6 → `lb` 0x6 = 0xFFFFFF80; `lbu` 0x6 = 0x00000080; `lw` 0x4 = 0x12805678.
  - `sh` 0xBEEF to 0x4 → `lh` 0x4 = 0xFFFFBEEF; `lhu` 0x4 = 0x0000BEEF; `lw` 0x4 = 0x1280BEEF.
- Misaligned and out-of-range:
  - `sw` to 0x5 → `addrExc`=1, no commit, no log, `lw` 0x4 unchanged.
  - `sh` to 0x3 → `addrExc`=1.
  - `lw` 0x40 → `addrExc`=1, `readData`=0.
- Reset mid-sweep and blocked store: assert `reset`=0 at sweep cycle 7, then release → `busy` high for 16 further edges. An `sw` 0xFFFFFFFF to 0x8 issued while `busy` leaves `lw` 0x8 = 0 after the sweep.
